stream_demux: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshake: the distributing counterpart of the WIDTH-bit 2-to-1 `multiplexer`. A word presented on the input port is steered by `in_sel` into one of two one-entry output holding slots, each drained independently by its consumer. It sits between a single producer and two datapath consumers, for example splitting operands between two processing lanes. Per-lane transfer counters support debug and verification.

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_slot.sv | 57 +++++
 rtl/stream_demux.sv | 57 +++++
 tb/tb_stream_demux.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: slot state encoding
// and default widths.
package demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding slot with valid/ready and a wrapping drain counter.
// free_c tells the steering logic whether a word can land here this cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             free_c
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    drain   = (state_q == SLOT_FULL) && ready_i;
    unique case (state_q)
      SLOT_EMPTY: if (acc_i) state_d = SLOT_FULL;
      SLOT_FULL:  if (drain && !acc_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    if (acc_i) data_d = data_i;
    if (drain) cnt_d = cnt_q + CNT_W'(1);
  end

  // A full slot being drained this cycle can take a refill in the same edge.
  assign free_c  = (state_q == SLOT_EMPTY) || ready_i;
  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer: steers each input word into one of
// two independently drained holding slots selected by in_sel.
module stream_demux
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic free0_c, free1_c;
  logic acc0, acc1;

  // Only the selected lane gates the input, so a stalled lane never blocks the other.
  assign in_ready = in_sel ? free1_c : free0_c;
  assign acc0     = in_valid && in_ready && !in_sel;
  assign acc1     = in_valid && in_ready &&  in_sel;

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .acc_i   (acc0),
    .data_i  (in_data),
    .ready_i (out0_ready),
    .valid_o (out0_valid),
    .data_o  (out0_data),
    .cnt_o   (cnt0),
    .free_c  (free0_c)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .acc_i   (acc1),
    .data_i  (in_data),
    .ready_i (out1_ready),
    .valid_o (out1_valid),
    .data_o  (out1_data),
    .cnt_o   (cnt1),
    .free_c  (free1_c)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux: reset, single word,
// backpressure, pass-through refill, and long alternating stream with wrap.
module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out1_valid;
  logic       out0_ready, out1_ready;
  logic [7:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_en   = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int idx = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard drains just before the edge, then advance to 1 time unit past it.
  task automatic tick();
    logic [7:0] e;
    if (sb_en) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("sb0_underflow", 32'd1, 32'd0);
        else begin e = q0.pop_front(); check("stream_lane0_data", 32'(out0_data), 32'(e)); end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("sb1_underflow", 32'd1, 32'd0);
        else begin e = q1.pop_front(); check("stream_lane1_data", 32'(out1_data), 32'(e)); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w        = 8'((idx * 7 + 3) & 255);
      in_sel   = idx[0];
      in_data  = w;
      in_valid = 1'b1;
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (in_ready) begin
        if (in_sel) q1.push_back(w);
        else        q0.push_back(w);
      end
      idx++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out0_valid", 32'(out0_valid), 32'd0);
    check("rst_out1_valid", 32'(out1_valid), 32'd0);
    check("rst_out0_data", 32'(out0_data), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    // A word offered during reset must be discarded.
    in_data = 8'hEE; in_valid = 1'b1;
    tick();
    check("rst_discard_valid", 32'(out0_valid), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Single word to lane 0, held, then drained.
    in_data = 8'hA5; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_out0_valid", 32'(out0_valid), 32'd1);
    check("single_out0_data", 32'(out0_data), 32'hA5);
    check("single_out1_valid", 32'(out1_valid), 32'd0);
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    check("single_cnt0", 32'(cnt0), 32'd1);
    check("single_drained", 32'(out0_valid), 32'd0);

    // Backpressure on lane 0; lane 1 still accepts.
    in_data = 8'h33; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 8'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out0_data", 32'(out0_data), 32'h33);
      tick();
    end
    in_data = 8'h55; in_sel = 1'b1;
    #1;
    check("bp_lane1_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_out1_valid", 32'(out1_valid), 32'd1);
    check("bp_out1_data", 32'(out1_data), 32'h55);
    check("bp_out0_held", 32'(out0_data), 32'h33);
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    out0_ready = 1'b0; out1_ready = 1'b0;
    check("bp_cnt0", 32'(cnt0), 32'd2);
    check("bp_cnt1", 32'(cnt1), 32'd1);

    // Pass-through refill on lane 1.
    in_data = 8'h11; in_sel = 1'b1; in_valid = 1'b1;
    tick();
    in_data = 8'h22; out1_ready = 1'b1;
    #1;
    check("pt_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out1_ready = 1'b0;
    check("pt_out1_data", 32'(out1_data), 32'h22);
    check("pt_out1_valid", 32'(out1_valid), 32'd1);
    check("pt_cnt1", 32'(cnt1), 32'd2);

    // Fill lane 0 as well, then reset between edges.
    in_data = 8'h66; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_both_full", 32'({out0_valid, out1_valid}), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valids", 32'({out0_valid, out1_valid}), 32'd0);
    check("mid_rst_data", 32'({out0_data, out1_data}), 32'd0);
    check("mid_rst_cnts", 32'({cnt0, cnt1}), 32'd0);
    #1 rst = 1'b0;
    tick();

    // Alternating stream with both consumers always ready.
    out0_ready = 1'b1; out1_ready = 1'b1;
    sb_en = 1'b1;
    stream(300);
    tick();
    check("stream300_cnt0", 32'(cnt0), 32'd150);
    check("stream300_cnt1", 32'(cnt1), 32'd150);
    stream(724);
    tick();
    check("wrap_cnt0", 32'(cnt0), 32'd0);
    check("wrap_cnt1", 32'(cnt1), 32'd0);
    check("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
    check("wrap_valids", 32'({out0_valid, out1_valid}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
